// File: rtl/vgachargen_fill_ctrl_if.sv
// Command, host and map-port signals of the vgachargen fill/scroll sequencer.
// The slave modport is the sequencer's view; master is the surrounding system.
interface vgachargen_fill_ctrl_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [1:0]        cmd_op_i;
    logic [7:0]        fill_ch_i;
    logic [7:0]        fill_col_i;
    logic              host_req_i;
    logic              host_we_i;
    logic [ADDR_W-1:0] host_addr_i;
    logic [7:0]        host_ch_i;
    logic [7:0]        host_col_i;
    logic              host_gnt_o;
    logic              host_rvalid_o;
    logic [7:0]        host_ch_o;
    logic [7:0]        host_col_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [7:0]        mem_ch_o;
    logic [7:0]        mem_col_o;
    logic [7:0]        mem_ch_i;
    logic [7:0]        mem_col_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    modport master (
        output cmd_valid_i, cmd_op_i, fill_ch_i, fill_col_i,
        output host_req_i, host_we_i, host_addr_i, host_ch_i, host_col_i,
        output mem_ch_i, mem_col_i,
        input  cmd_ready_o, host_gnt_o, host_rvalid_o, host_ch_o, host_col_o,
        input  mem_addr_o, mem_we_o, mem_ch_o, mem_col_o, busy_o, done_o, err_o
    );

    modport slave (
        input  cmd_valid_i, cmd_op_i, fill_ch_i, fill_col_i,
        input  host_req_i, host_we_i, host_addr_i, host_ch_i, host_col_i,
        input  mem_ch_i, mem_col_i,
        output cmd_ready_o, host_gnt_o, host_rvalid_o, host_ch_o, host_col_o,
        output mem_addr_o, mem_we_o, mem_ch_o, mem_col_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/vgachargen_fill_ctrl.sv
// Clear/scroll-up sequencer for the character map, sharing one map port with a
// host that has priority, bounded by a starvation guard.
module vgachargen_fill_ctrl #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 30,
    parameter int unsigned ADDR_W = $clog2(COLS * ROWS)
) (
    input logic                   clk_i,
    input logic                   rstn_i,
    vgachargen_fill_ctrl_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StClr, StScrRd, StScrWr, StScrFill} state_e;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LastScr = ADDR_W'(COLS * (ROWS - 1) - 1);
    localparam logic [ADDR_W-1:0] RowOfs  = ADDR_W'(COLS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        fill_ch_q, fill_ch_d, fill_col_q, fill_col_d;
    logic [7:0]        hold_ch_q, hold_col_q;
    logic              first_wr_q;
    logic [2:0]        starve_q, starve_d;
    logic              done_q, done_d, err_q, err_d, rvalid_q;
    logic              busy, force_eng, host_gnt, eng_go;
    logic              eng_we;
    logic [ADDR_W-1:0] eng_addr;
    logic [7:0]        eng_ch, eng_col;

    assign busy      = (state_q != StIdle);
    assign force_eng = busy && (starve_q == 3'd4);
    assign host_gnt  = bus.host_req_i & ~force_eng;
    assign eng_go    = busy & ~host_gnt;
    assign starve_d  = (busy && host_gnt) ? starve_q + 3'd1 : 3'd0;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        fill_ch_d  = fill_ch_q;
        fill_col_d = fill_col_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        eng_we     = 1'b0;
        eng_addr   = idx_q;
        eng_ch     = fill_ch_q;
        eng_col    = fill_col_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid_i) begin
                    fill_ch_d  = bus.fill_ch_i;
                    fill_col_d = bus.fill_col_i;
                    idx_d      = '0;
                    case (bus.cmd_op_i)
                        2'd0:    state_d = StClr;
                        2'd1:    state_d = StScrRd;
                        default: err_d   = 1'b1;
                    endcase
                end
            end
            StClr, StScrFill: begin
                eng_we = 1'b1;
                if (eng_go) begin
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StScrRd: begin
                eng_addr = idx_q + RowOfs;
                if (eng_go) state_d = StScrWr;
            end
            StScrWr: begin
                eng_we = 1'b1;
                // Read data is only on the port in the first cycle; later cycles use the hold copy.
                eng_ch  = first_wr_q ? bus.mem_ch_i : hold_ch_q;
                eng_col = first_wr_q ? bus.mem_col_i : hold_col_q;
                if (eng_go) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = (idx_q == LastScr) ? StScrFill : StScrRd;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.mem_addr_o = '0;
        bus.mem_we_o   = 1'b0;
        bus.mem_ch_o   = '0;
        bus.mem_col_o  = '0;
        if (host_gnt) begin
            bus.mem_addr_o = bus.host_addr_i;
            bus.mem_we_o   = bus.host_we_i;
            bus.mem_ch_o   = bus.host_ch_i;
            bus.mem_col_o  = bus.host_col_i;
        end else if (busy) begin
            bus.mem_addr_o = eng_addr;
            bus.mem_we_o   = eng_we;
            bus.mem_ch_o   = eng_ch;
            bus.mem_col_o  = eng_col;
        end
    end

    assign bus.cmd_ready_o   = ~busy;
    assign bus.busy_o        = busy;
    assign bus.done_o        = done_q;
    assign bus.err_o         = err_q;
    assign bus.host_gnt_o    = host_gnt;
    assign bus.host_rvalid_o = rvalid_q;
    assign bus.host_ch_o     = rvalid_q ? bus.mem_ch_i : 8'h00;
    assign bus.host_col_o    = rvalid_q ? bus.mem_col_i : 8'h00;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            fill_ch_q  <= '0;
            fill_col_q <= '0;
            hold_ch_q  <= '0;
            hold_col_q <= '0;
            first_wr_q <= 1'b0;
            starve_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            fill_ch_q  <= fill_ch_d;
            fill_col_q <= fill_col_d;
            first_wr_q <= (state_q == StScrRd) && eng_go;
            if (first_wr_q) begin
                hold_ch_q  <= bus.mem_ch_i;
                hold_col_q <= bus.mem_col_i;
            end
            starve_q <= starve_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rvalid_q <= host_gnt & ~bus.host_we_i;
        end
    end
endmodule

// File: tb/tb_vgachargen_fill_ctrl.sv
// Bench for vgachargen_fill_ctrl: map memory model, host traffic generator and a
// scoreboard of expected engine writes and host read data.
module tb_vgachargen_fill_ctrl;
    localparam int unsigned COLS   = 80;
    localparam int unsigned ROWS   = 30;
    localparam int unsigned CELLS  = COLS * ROWS;
    localparam int unsigned ADDR_W = 12;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    vgachargen_fill_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    vgachargen_fill_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int host_mode = 0;  // 0 off, 1 rand reads, 2 rand rd/wr, 3 always rd/wr, 4 read addr 5
    logic preload_req = 1'b0;
    logic [15:0] mem [4096];
    logic [15:0] ref_map [4096];
    logic [15:0] rd_q;
    wr_t         exp_wr_q [$];
    logic [15:0] exp_rd_q [$];

    function automatic logic [15:0] pat(input int a);
        logic [31:0] v;
        v = a;
        return {v[7:0], 8'(v * 7 + 3)};
    endfunction

    // Map memory: synchronous read, one-cycle latency.
    always @(posedge clk) begin
        if (preload_req) begin
            for (int a = 0; a < CELLS; a++) mem[a] <= pat(a);
        end else if (bus.mem_we_o === 1'b1) begin
            mem[bus.mem_addr_o] <= {bus.mem_ch_o, bus.mem_col_o};
        end
        rd_q <= mem[bus.mem_addr_o];
    end
    assign bus.mem_ch_i  = rd_q[15:8];
    assign bus.mem_col_i = rd_q[7:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got 0x%0h, expected nothing at %0t", name, act, $time);
    endtask

    // Host traffic generator.
    initial begin
        bus.host_req_i  = 1'b0;
        bus.host_we_i   = 1'b0;
        bus.host_addr_i = '0;
        bus.host_ch_i   = '0;
        bus.host_col_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.host_req_i  = 1'b0;
            bus.host_we_i   = 1'b0;
            bus.host_addr_i = ADDR_W'($urandom_range(CELLS - 1, 0));
            bus.host_ch_i   = 8'($urandom);
            bus.host_col_i  = 8'($urandom);
            if (host_mode == 1) begin
                bus.host_req_i = 1'($urandom_range(1, 0));
            end else if (host_mode == 2) begin
                bus.host_req_i = 1'($urandom_range(1, 0));
                bus.host_we_i  = 1'($urandom_range(1, 0));
            end else if (host_mode == 3) begin
                bus.host_req_i = 1'b1;
                bus.host_we_i  = 1'($urandom_range(1, 0));
            end else if (host_mode == 4) begin
                bus.host_req_i  = 1'b1;
                bus.host_addr_i = ADDR_W'(5);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a write or read data.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (preload_req) for (int a = 0; a < CELLS; a++) ref_map[a] = pat(a);
            if (bus.host_rvalid_o === 1'b1) begin
                if (exp_rd_q.size() == 0) note_fail("host_rd_unexpected", {bus.host_ch_o, bus.host_col_o});
                else check("host_rd_data", {bus.host_ch_o, bus.host_col_o}, exp_rd_q.pop_front());
            end
            if (bus.host_gnt_o === 1'b1) begin
                if (bus.host_we_i) ref_map[bus.host_addr_i] = {bus.host_ch_i, bus.host_col_i};
                else exp_rd_q.push_back(ref_map[bus.host_addr_i]);
            end else if (bus.mem_we_o === 1'b1) begin
                if (exp_wr_q.size() == 0) begin
                    note_fail("eng_wr_unexpected", bus.mem_addr_o);
                end else begin
                    w = exp_wr_q.pop_front();
                    check("eng_wr_addr", bus.mem_addr_o, w.addr);
                    check("eng_wr_data", {bus.mem_ch_o, bus.mem_col_o}, w.data);
                    ref_map[w.addr] = w.data;
                end
            end
        end
    end

    task automatic push_fill(input int from, input logic [7:0] ch, input logic [7:0] col);
        wr_t w;
        for (int i = from; i < CELLS; i++) begin
            w.addr = ADDR_W'(i);
            w.data = {ch, col};
            exp_wr_q.push_back(w);
        end
    endtask

    // Scroll-up: every row moves up one, bottom row gets the fill values.
    task automatic push_scroll(input logic [7:0] ch, input logic [7:0] col);
        wr_t w;
        for (int i = 0; i < CELLS - COLS; i++) begin
            w.addr = ADDR_W'(i);
            w.data = ref_map[i + COLS];
            exp_wr_q.push_back(w);
        end
        push_fill(CELLS - COLS, ch, col);
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] ch, input logic [7:0] col);
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = op;
        bus.fill_ch_i   = ch;
        bus.fill_col_i  = col;
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic preload();
        @(posedge clk);
        #1 preload_req = 1'b1;
        @(posedge clk);
        #1 preload_req = 1'b0;
    endtask

    task automatic wait_done(input int start, input int limit, input bit track,
                             output int cyc, output int bcyc, output int hg, output int gerr);
        cyc = start; bcyc = 0; hg = 0; gerr = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.busy_o) begin
                bcyc++;
                if (bus.host_gnt_o) hg++;
                if (track && (bus.host_gnt_o !== ((cyc - 1) % 5 != 4))) gerr++;
            end
            if (bus.done_o) break;
            if (cyc >= limit) begin
                note_fail("done_timeout", cyc);
                break;
            end
        end
    endtask

    initial begin
        int cyc, bcyc, hg, gerr, dcnt, bad;
        logic [7:0] fc, fl;
        rstn            = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i    = '0;
        bus.fill_ch_i   = '0;
        bus.fill_col_i  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready_o, 1);
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);
        check("rst_err", bus.err_o, 0);
        check("rst_gnt", bus.host_gnt_o, 0);
        check("rst_rvalid", bus.host_rvalid_o, 0);
        check("rst_mem_we", bus.mem_we_o, 0);
        check("rst_mem_addr", bus.mem_addr_o, 0);
        check("rst_mem_data", {bus.mem_ch_o, bus.mem_col_o}, 0);
        check("rst_host_data", {bus.host_ch_o, bus.host_col_o}, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        preload();

        // Plain clear.
        push_fill(0, 8'h20, 8'h0F);
        issue(2'd0, 8'h20, 8'h0F);
        wait_done(0, 6000, 1'b0, cyc, bcyc, hg, gerr);
        check("clr_done_cycle", cyc, 2401);
        check("clr_busy_cycles", bcyc, 2400);
        check("clr_ready_at_done", bus.cmd_ready_o, 1);
        @(negedge clk);
        check("clr_done_pulse", bus.done_o, 0);

        // Plain scroll over a known pattern.
        preload();
        push_scroll(8'h00, 8'h07);
        issue(2'd1, 8'h00, 8'h07);
        wait_done(0, 10000, 1'b0, cyc, bcyc, hg, gerr);
        check("scr_done_cycle", cyc, 4721);
        check("scr_busy_cycles", bcyc, 4720);
        @(negedge clk);
        check("scr_addr0", mem[0][15:8], 80);
        check("scr_addr2319", mem[2319][15:8], 8'h5F);
        check("scr_addr2320", mem[2320], 16'h0007);
        check("scr_addr2399", mem[2399], 16'h0007);

        // Host read lands on the first SCR_WR cycle; scroll must still write the held data.
        preload();
        push_scroll(8'h11, 8'h22);
        issue(2'd1, 8'h11, 8'h22);
        #1 host_mode = 4;
        @(negedge clk);
        @(negedge clk);
        check("pre_gnt", bus.host_gnt_o, 1);
        host_mode = 0;
        @(negedge clk);
        check("pre_rvalid", bus.host_rvalid_o, 1);
        check("pre_rdata", {bus.host_ch_o, bus.host_col_o}, pat(5));
        wait_done(3, 10000, 1'b0, cyc, bcyc, hg, gerr);
        check("pre_done_cycle", cyc, 4722);

        // Starvation: host always requesting.
        fc = 8'($urandom);
        fl = 8'($urandom);
        push_fill(0, fc, fl);
        host_mode = 3;
        issue(2'd0, fc, fl);
        wait_done(0, 13000, 1'b1, cyc, bcyc, hg, gerr);
        host_mode = 0;
        check("stv_done_cycle", cyc, 2400 * 5 + 1);
        check("stv_gnt_pattern_errs", gerr, 0);
        repeat (3) @(negedge clk);

        // Random fills and scrolls with random host traffic.
        for (int k = 0; k < 2; k++) begin
            fc = 8'($urandom);
            fl = 8'($urandom);
            push_fill(0, fc, fl);
            host_mode = 2;
            issue(2'd0, fc, fl);
            wait_done(0, 9000, 1'b0, cyc, bcyc, hg, gerr);
            host_mode = 0;
            check("rnd_clr_latency", cyc, 2401 + hg);
            repeat (3) @(negedge clk);
            fc = 8'($urandom);
            fl = 8'($urandom);
            push_scroll(fc, fl);
            host_mode = 1;
            issue(2'd1, fc, fl);
            wait_done(0, 16000, 1'b0, cyc, bcyc, hg, gerr);
            host_mode = 0;
            check("rnd_scr_latency", cyc, 4721 + hg);
            repeat (3) @(negedge clk);
        end

        // Reserved ops.
        for (int op = 2; op < 4; op++) begin
            issue(2'(op), 8'hAA, 8'h55);
            @(negedge clk);
            check("rsv_err_pulse", bus.err_o, 1);
            check("rsv_busy", bus.busy_o, 0);
            check("rsv_mem_we", bus.mem_we_o, 0);
            @(negedge clk);
            check("rsv_err_clear", bus.err_o, 0);
        end

        // Reset in the middle of a clear.
        push_fill(0, 8'h41, 8'h1E);
        issue(2'd0, 8'h41, 8'h1E);
        repeat (99) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", bus.cmd_ready_o, 1);
        check("mid_rst_we", bus.mem_we_o, 0);
        check("mid_rst_busy", bus.busy_o, 0);
        check("mid_rst_writes_left", exp_wr_q.size(), 2300);
        exp_wr_q.delete();
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done_o) dcnt++;
        end
        check("mid_rst_no_done", dcnt, 0);

        bad = 0;
        for (int a = 0; a < CELLS; a++) if (mem[a] !== ref_map[a]) bad++;
        check("final_map_cells_wrong", bad, 0);
        check("final_rd_pending", exp_rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vgachargen_fill_ctrl.md
# vgachargen_fill_ctrl

Bulk-operation sequencer and port arbiter for the vgachargen 80×30 character/colour map. It accepts clear-screen and scroll-up commands and walks the map, issuing reads and writes on one shared map port. A host port (the APB side) shares the same map port: the host has priority, and a starvation guard ensures the engine keeps making progress.

## Interface
- `COLS`, 80, characters per row
- `ROWS`, 30, rows per screen
- `ADDR_W`, `$clog2(COLS*ROWS)` = 12, map address width
---
- `clk_i`  in  1  single clock
- `rstn_i`  in  1  reset, synchronous, active-low
- `cmd_valid_i`  in  1  command request
- `cmd_ready_o`  out  1  command accepted when high with `cmd_valid_i`
- `cmd_op_i`  in  2  0 = clear, 1 = scroll-up, 2/3 = reserved
- `fill_ch_i` / `fill_col_i`  in  8 / 8  fill character and colour; sampled at command accept
- `host_req_i`  in  1  host access request
- `host_we_i`  in  1  host write (1) or read (0)
- `host_addr_i`  in  `ADDR_W`  host map address
- `host_ch_i` / `host_col_i`  in  8 / 8  host write data
- `host_gnt_o`  out  1  host owns the map port this cycle
- `host_rvalid_o`  out  1  host read data valid
- `host_ch_o` / `host_col_o`  out  8 / 8  host read data
- `mem_addr_o`  out  `ADDR_W`  map port address
- `mem_we_o`  out  1  map port write enable
- `mem_ch_o` / `mem_col_o`  out  8 / 8  map write data
- `mem_ch_i` / `mem_col_i`  in  8 / 8  map read data, valid 1 cycle after the read address
- `busy_o`  out  1  engine active
- `done_o`  out  1  one-cycle pulse when a command completes
- `err_o`  out  1  one-cycle pulse when a reserved op is accepted

## Operation
- **States:** IDLE, CLR, SCR_RD, SCR_WR, SCR_FILL.
- `cmd_ready_o` = (state == IDLE). `busy_o` = (state != IDLE).
- **Accept:** `cmd_valid_i & cmd_ready_o` at an edge. The engine latches the op and fill values, sets idx = 0, and moves to:
  - CLR for op 0;
  - SCR_RD for op 1;
  - stays in IDLE for op 2/3 and pulses `err_o` on the next cycle.
- **CLR:** each engine-owned cycle writes the fill values at idx, then idx++. After idx = 2399: go to IDLE and pulse `done_o`.
- **SCR_RD:** an engine-owned cycle reads addr idx+80, then goes to SCR_WR.
- **SCR_WR:**
  - In its first cycle, always capture `mem_ch_i`/`mem_col_i` into a hold register, even if the host owns the port.
  - On an engine-owned cycle, write the hold data at idx, then idx++.
  - After idx = 2319: go to SCR_FILL. Otherwise go back to SCR_RD.
- **SCR_FILL:** writes the fill values at 2320..2399, then goes to IDLE and pulses `done_o`.
- **Arbitration:**
  - `host_gnt_o` = `host_req_i & ~force_eng`.
  - `mem_*_o` comes from the host when it is granted. Otherwise it comes from the engine when busy. Otherwise `mem_we_o` = 0.
  - In IDLE the host is always granted.
- **Starvation guard:**
  - A 3-bit counter increments each cycle with `busy_o & host_gnt_o`.
  - When it reaches 4, `force_eng` = 1 for the next cycle. The host is denied that cycle and must hold its request.
  - The counter clears on any engine-owned cycle and in IDLE.
- **Host read:** `host_rvalid_o` goes high the cycle after a granted read, with `host_ch_o`/`host_col_o` = `mem_ch_i`/`mem_col_i` (combinational pass-through).
- **Address math:** idx is `ADDR_W` unsigned and does not wrap; the terminal compares are against 2399, 2319 and 2399. The read address idx+80 is at most 2399.
- **Reset mid-operation:** return to IDLE and abandon the operation. Map contents are left partially updated.

## Timing
- **Reset values:** `cmd_ready_o`=1, `busy_o`=0, `done_o`=0, `err_o`=0, `host_gnt_o`=`host_req_i` (combinational), `host_rvalid_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_ch_o`=0, `mem_col_o`=0, `host_ch_o`=0, `host_col_o`=0. All registers clear on a `rstn_i` low edge-sample.
- **First engine access:** the cycle after accept.
- **Clear, no host traffic:** 2400 write cycles. `done_o` is high in cycle 2401 after accept, and `cmd_ready_o` is high in the same cycle.
- **Scroll, no host traffic:** 2320×2 + 80 = 4720 engine cycles. `done_o` is at cycle 4721.
- Each host-granted cycle adds one cycle of latency to the engine.
- A new command can be accepted in the same cycle `done_o` is high.

## Test plan
- **Clear:** op=0, fill_ch=0x20, fill_col=0x0F, idle host → 2400 writes to addr 0..2399 with 0x20/0x0F. `done_o` at cycle 2401. `busy_o` high for 2400 cycles.
- **Scroll:** map preloaded so ch = addr[7:0]; op=1, fill_ch=0x00 → addr 0 holds 80, addr 2319 holds 2399[7:0]=0x5F, and 2320..2399 hold 0x00. `done_o` at cycle 4721.
- **Host preemption with hold:** during scroll, assert `host_req_i` (read, addr 5) in the first SCR_WR cycle.
  - Required: `host_gnt_o`=1 and `host_rvalid_o` on the next cycle with addr-5 data.
  - Required: the scroll's later write at idx uses the captured data, not the host data.
- **Starvation:** `host_req_i` held high through a clear → `host_gnt_o` pattern 1,1,1,1,0 repeating; completion at 2400×5 + 1 cycles.
- **Reserved op and reset:** op=3 → `err_o` pulse on the next cycle, `busy_o` stays 0, no map write. Then start a clear and drop `rstn_i` at cycle 100 → IDLE with `cmd_ready_o`=1 and `mem_we_o`=0 on the following cycle, and no `done_o`.
